// File: rtl/map_dlatch_pkg.sv
// Shared constants and field-mapping helper for the discrete-latch mapper.
// Used by map_dlatch and its testbench.
package map_dlatch_pkg;

  localparam int MODE_NINA  = 0;
  localparam int MODE_GXROM = 1;
  localparam int MODE_CD    = 2;

  localparam logic [7:0] SS_PRG  = 8'd0;
  localparam logic [7:0] SS_CHR  = 8'd1;
  localparam logic [7:0] SS_MIR  = 8'd2;
  localparam logic [7:0] SS_WCNT = 8'd3;
  localparam logic [7:0] SS_IDX  = 8'd127;

  typedef struct packed {
    logic [3:0] prg;
    logic [3:0] chr;
    logic       mir_we;
    logic       mir;
  } fields_t;

  function automatic fields_t map_fields(
    input int         mode,
    input logic [7:0] d
  );
    fields_t f;
    f = '0;
    case (mode)
      MODE_GXROM: begin
        f.prg = {2'b00, d[5:4]};
        f.chr = {2'b00, d[1:0]};
      end
      MODE_CD: begin
        f.prg = {2'b00, d[1:0]};
        f.chr = d[7:4];
      end
      default: begin
        f.prg    = {1'b0, d[5:3]};
        f.chr    = {d[6], d[2:0]};
        f.mir_we = 1'b1;
        f.mir    = d[7];
      end
    endcase
    return f;
  endfunction

endpackage

// File: rtl/m2_edge_sync.sv
// Two-flop synchroniser for the CPU M2 strobe with a falling-edge pulse.
// Generic so other mappers can reuse it.
module m2_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_hi,
  output logic fall
);

  logic sync0;
  logic sync1;
  logic sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync0  <= async_in;
      sync1  <= sync0;
      sync_d <= sync1;
    end
  end

  assign sync_hi = sync1;
  assign fall    = sync_d & ~sync1;

endmodule

// File: rtl/map_dlatch.sv
// Discrete-latch mapper core: NINA-03/06, Sachen 113, GxROM, Color Dreams.
// Latches bank/mirroring from a decoded CPU write on the M2 falling edge.
module map_dlatch
  import map_dlatch_pkg::*;
#(
  parameter int          MODE         = MODE_NINA,
  parameter int          PRG_BITS     = 3,
  parameter int          CHR_BITS     = 4,
  parameter logic [15:0] DEC_MASK     = 16'hE100,
  parameter logic [15:0] DEC_MATCH    = 16'h4100,
  parameter bit          BUS_CONFLICT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m2,
  input  logic        cpu_ce,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dat,
  input  logic [7:0]  rom_dat,
  input  logic [13:0] ppu_addr,
  input  logic        ppu_oe,
  input  logic        cfg_mir_v,
  input  logic        ss_act,
  input  logic        ss_we,
  input  logic [7:0]  ss_addr,
  output logic [18:0] prg_addr,
  output logic [16:0] chr_addr,
  output logic        ciram_a10,
  output logic        ciram_ce,
  output logic        rom_ce,
  output logic        prg_oe,
  output logic        chr_oe,
  output logic [7:0]  ss_rdat
);

  localparam logic [3:0] PRG_MASK = 4'((1 << PRG_BITS) - 1);
  localparam logic [3:0] CHR_MASK = 4'((1 << CHR_BITS) - 1);

  logic        m2_hi;
  logic        m2_fall;
  logic [14:0] h_addr;
  logic        h_ce;
  logic [7:0]  h_dat;
  logic        h_rw;
  logic [7:0]  rom_dat_h;
  logic [3:0]  prg;
  logic [3:0]  chr;
  logic        mir;
  logic [7:0]  wr_cnt;
  logic [7:0]  d_eff;
  logic        dec_hit;
  logic        cpu_wr;
  logic        ss_wr;
  fields_t     fld;
  logic        unused_bits;

  // Bit 15 comes from cpu_ce, so the raw bus bit is ignored.
  assign unused_bits = cpu_addr[15];

  m2_edge_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (m2),
    .sync_hi  (m2_hi),
    .fall     (m2_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_addr    <= '0;
      h_ce      <= 1'b0;
      h_dat     <= '0;
      h_rw      <= 1'b0;
      rom_dat_h <= '0;
    end else if (m2_hi) begin
      h_addr    <= cpu_addr[14:0];
      h_ce      <= cpu_ce;
      h_dat     <= cpu_dat;
      h_rw      <= cpu_rw;
      rom_dat_h <= rom_dat;
    end
  end

  assign dec_hit = (({h_ce, h_addr} & DEC_MASK) == DEC_MATCH);
  assign cpu_wr  = m2_fall & ~h_rw & dec_hit & ~ss_act;
  assign ss_wr   = m2_fall & ss_act & ss_we;
  assign d_eff   = BUS_CONFLICT ? (h_dat & rom_dat_h) : h_dat;
  assign fld     = map_fields(MODE, d_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prg    <= '0;
      chr    <= '0;
      mir    <= 1'b0;
      wr_cnt <= '0;
    end else if (ss_wr) begin
      unique case (1'b1)
        (ss_addr == SS_PRG):  prg    <= h_dat[3:0] & PRG_MASK;
        (ss_addr == SS_CHR):  chr    <= h_dat[3:0] & CHR_MASK;
        (ss_addr == SS_MIR):  mir    <= h_dat[0];
        (ss_addr == SS_WCNT): wr_cnt <= h_dat;
        default: ;
      endcase
    end else if (cpu_wr) begin
      prg <= fld.prg & PRG_MASK;
      chr <= fld.chr & CHR_MASK;
      if (fld.mir_we) mir <= fld.mir;
      if (wr_cnt != 8'hFF) wr_cnt <= wr_cnt + 8'd1;
    end
  end

  always_comb begin
    ss_rdat = 8'hFF;
    unique case (1'b1)
      (ss_addr == SS_PRG):  ss_rdat = {4'h0, prg};
      (ss_addr == SS_CHR):  ss_rdat = {4'h0, chr};
      (ss_addr == SS_MIR):  ss_rdat = {7'h00, mir};
      (ss_addr == SS_WCNT): ss_rdat = wr_cnt;
      (ss_addr == SS_IDX):  ss_rdat = 8'(MODE);
      default:              ss_rdat = 8'hFF;
    endcase
  end

  assign prg_addr  = {prg, cpu_addr[14:0]};
  assign chr_addr  = {chr, ppu_addr[12:0]};
  assign ciram_a10 = (mir | cfg_mir_v) ? ppu_addr[10] : ppu_addr[11];
  assign ciram_ce  = ~ppu_addr[13];
  assign rom_ce    = ~cpu_ce;
  assign prg_oe    = cpu_rw;
  assign chr_oe    = ~ppu_oe;

endmodule

// File: tb/tb_map_dlatch.sv
// Scoreboard bench for map_dlatch: NINA instance plus a Color Dreams
// instance with bus conflicts, driven from the same bus.
module tb_map_dlatch;
  import map_dlatch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m2;
  logic        cpu_ce;
  logic        cpu_rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic [7:0]  rom_dat;
  logic [13:0] ppu_addr;
  logic        ppu_oe;
  logic        cfg_mir_v;
  logic        ss_act;
  logic        ss_we;
  logic [7:0]  ss_addr;

  logic [18:0] a_prg_addr, b_prg_addr;
  logic [16:0] a_chr_addr, b_chr_addr;
  logic        a_a10, b_a10, a_cice, b_cice, a_romce, b_romce;
  logic        a_prgoe, b_prgoe, a_chroe, b_chroe;
  logic [7:0]  a_ss, b_ss;

  always #5 clk = ~clk;

  map_dlatch u_a (
    .clk(clk), .rst_n(rst_n), .m2(m2), .cpu_ce(cpu_ce),
    .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat),
    .rom_dat(rom_dat), .ppu_addr(ppu_addr), .ppu_oe(ppu_oe),
    .cfg_mir_v(cfg_mir_v), .ss_act(ss_act), .ss_we(ss_we),
    .ss_addr(ss_addr), .prg_addr(a_prg_addr), .chr_addr(a_chr_addr),
    .ciram_a10(a_a10), .ciram_ce(a_cice), .rom_ce(a_romce),
    .prg_oe(a_prgoe), .chr_oe(a_chroe), .ss_rdat(a_ss)
  );

  map_dlatch #(
    .MODE(MODE_CD), .PRG_BITS(3), .CHR_BITS(4),
    .DEC_MASK(16'h8000), .DEC_MATCH(16'h8000), .BUS_CONFLICT(1'b1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .m2(m2), .cpu_ce(cpu_ce),
    .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat),
    .rom_dat(rom_dat), .ppu_addr(ppu_addr), .ppu_oe(ppu_oe),
    .cfg_mir_v(cfg_mir_v), .ss_act(ss_act), .ss_we(ss_we),
    .ss_addr(ss_addr), .prg_addr(b_prg_addr), .chr_addr(b_chr_addr),
    .ciram_a10(b_a10), .ciram_ce(b_cice), .rom_ce(b_romce),
    .prg_oe(b_prgoe), .chr_oe(b_chroe), .ss_rdat(b_ss)
  );

  int          mode_k [2] = '{0, 2};
  bit          bc_k   [2] = '{1'b0, 1'b1};
  logic [15:0] mask_k [2] = '{16'hE100, 16'h8000};
  logic [15:0] match_k[2] = '{16'h4100, 16'h8000};
  int m_prg[2], m_chr[2], m_mir[2], m_cnt[2];

  typedef struct {
    string       tag;
    bit          ss;
    logic [18:0] pa0, pa1;
    logic [16:0] ca0, ca1;
    logic        a10_0, a10_1;
    logic [3:0]  misc;
    logic [7:0]  ss0, ss1;
  } exp_t;

  exp_t q[$];
  bit   req = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic cmp(string tag, string what, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h want %h", tag, what, act, exp);
    end
  endtask

  // Monitor: compares whenever the stimulus side presents a sample point.
  always @(negedge clk) begin
    if (req) begin
      exp_t e;
      if (q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL scoreboard: got empty queue want entry");
      end else begin
        e = q.pop_front();
        cmp(e.tag, "a_prg_addr", 32'(a_prg_addr), 32'(e.pa0));
        cmp(e.tag, "b_prg_addr", 32'(b_prg_addr), 32'(e.pa1));
        cmp(e.tag, "a_chr_addr", 32'(a_chr_addr), 32'(e.ca0));
        cmp(e.tag, "b_chr_addr", 32'(b_chr_addr), 32'(e.ca1));
        cmp(e.tag, "a_a10", 32'(a_a10), 32'(e.a10_0));
        cmp(e.tag, "b_a10", 32'(b_a10), 32'(e.a10_1));
        cmp(e.tag, "a_misc", 32'({a_cice, a_romce, a_prgoe, a_chroe}), 32'(e.misc));
        cmp(e.tag, "b_misc", 32'({b_cice, b_romce, b_prgoe, b_chroe}), 32'(e.misc));
        if (e.ss) begin
          cmp(e.tag, "a_ss_rdat", 32'(a_ss), 32'(e.ss0));
          cmp(e.tag, "b_ss_rdat", 32'(b_ss), 32'(e.ss1));
        end
      end
      req = 1'b0;
    end
  end

  function automatic int ss_model(int k, int idx);
    case (idx)
      0:       return m_prg[k];
      1:       return m_chr[k];
      2:       return m_mir[k];
      3:       return m_cnt[k];
      127:     return mode_k[k];
      default: return 255;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_prg[k] = 0; m_chr[k] = 0; m_mir[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_apply(logic [15:0] a, logic [7:0] d, logic rw,
                             logic [7:0] rom, bit sa, bit sw, int si);
    for (int k = 0; k < 2; k++) begin
      int v;
      if (sa) begin
        if (sw) begin
          case (si)
            0: m_prg[k] = d % 8;
            1: m_chr[k] = d % 16;
            2: m_mir[k] = d % 2;
            3: m_cnt[k] = d;
            default: ;
          endcase
        end
      end else if (!rw && ((a & mask_k[k]) == match_k[k])) begin
        v = bc_k[k] ? int'(d & rom) : int'(d);
        if (mode_k[k] == 0) begin
          m_prg[k] = (v / 8) % 8;
          m_chr[k] = ((v / 64) % 2) * 8 + v % 8;
          m_mir[k] = v / 128;
        end else if (mode_k[k] == 1) begin
          m_prg[k] = (v / 16) % 4;
          m_chr[k] = v % 4;
        end else begin
          m_prg[k] = v % 4;
          m_chr[k] = v / 16;
        end
        if (m_cnt[k] < 255) m_cnt[k]++;
      end
    end
  endtask

  // Randomises passive inputs, queues the expectation, waits one cycle.
  task automatic check(string tag, bit ss);
    exp_t e;
    ppu_addr  = 14'($urandom);
    cfg_mir_v = 1'($urandom);
    ppu_oe    = 1'($urandom);
    cpu_addr  = 16'($urandom);
    cpu_ce    = cpu_addr[15];
    cpu_rw    = 1'($urandom);
    if (ss) begin
      ss_act = 1'b1;
      ss_we  = 1'b0;
      case ($urandom_range(0, 5))
        0: ss_addr = 8'd0;
        1: ss_addr = 8'd1;
        2: ss_addr = 8'd2;
        3: ss_addr = 8'd3;
        4: ss_addr = 8'd127;
        default: ss_addr = 8'($urandom_range(4, 126));
      endcase
    end
    e.tag   = tag;
    e.ss    = ss;
    e.pa0   = {4'(m_prg[0]), cpu_addr[14:0]};
    e.pa1   = {4'(m_prg[1]), cpu_addr[14:0]};
    e.ca0   = {4'(m_chr[0]), ppu_addr[12:0]};
    e.ca1   = {4'(m_chr[1]), ppu_addr[12:0]};
    e.a10_0 = (m_mir[0] != 0 || cfg_mir_v) ? ppu_addr[10] : ppu_addr[11];
    e.a10_1 = (m_mir[1] != 0 || cfg_mir_v) ? ppu_addr[10] : ppu_addr[11];
    e.misc  = {~ppu_addr[13], ~cpu_ce, cpu_rw, ~ppu_oe};
    e.ss0   = 8'(ss_model(0, int'(ss_addr)));
    e.ss1   = 8'(ss_model(1, int'(ss_addr)));
    q.push_back(e);
    req = 1'b1;
    @(posedge clk);
    if (req) begin
      errors++;
      checks++;
      $display("FAIL %s.timeout: got no sample want sample", tag);
      req = 1'b0;
      q.delete();
    end
  endtask

  task automatic bus(logic [15:0] a, logic [7:0] d, logic rw, logic [7:0] rom,
                     bit sa, bit sw, int si, bit lat, string tag);
    @(posedge clk); #2;
    cpu_addr = a;
    cpu_ce   = a[15];
    cpu_dat  = d;
    cpu_rw   = rw;
    rom_dat  = rom;
    ss_act   = sa;
    ss_we    = sw;
    ss_addr  = 8'(si);
    m2       = 1'b1;
    repeat (5) @(posedge clk);
    #2 m2 = 1'b0;
    if (lat) begin
      @(posedge clk);
      @(posedge clk);
      #2 check({tag, "_pre"}, 1'b0);
      #2;
      model_apply(a, d, rw, rom, sa, sw, si);
      check({tag, "_lat"}, 1'b0);
      #2;
    end else begin
      repeat (3) @(posedge clk);
      #2 model_apply(a, d, rw, rom, sa, sw, si);
    end
    check(tag, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] a;
    rst_n = 1'b0; m2 = 1'b0; cpu_ce = 1'b0; cpu_rw = 1'b1;
    cpu_addr = '0; cpu_dat = '0; rom_dat = '0; ppu_addr = '0;
    ppu_oe = 1'b1; cfg_mir_v = 1'b0; ss_act = 1'b0; ss_we = 1'b0;
    ss_addr = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    check("reset", 1'b1);
    check("reset_idx", 1'b1);

    bus(16'h4000, 8'h12, 1'b0, 8'h00, 0, 0, 0, 0, "miss_4000");
    bus(16'h4100, 8'h3C, 1'b1, 8'h00, 0, 0, 0, 0, "read_4100");
    bus(16'h4100, 8'hD5, 1'b0, 8'h00, 0, 0, 0, 1, "nina_d5");
    bus(16'h8000, 8'hFF, 1'b0, 8'h31, 0, 0, 0, 1, "bus_conf");
    bus(16'h4100, 8'h0A, 1'b0, 8'h00, 1, 1, 1, 0, "ss_chr");
    bus(16'h4100, 8'h05, 1'b0, 8'h00, 1, 1, 0, 0, "ss_prg");
    bus(16'h4100, 8'h01, 1'b0, 8'h00, 1, 1, 2, 0, "ss_mir");
    bus(16'h4100, 8'hF0, 1'b0, 8'h00, 1, 1, 3, 0, "ss_cnt");

    for (int i = 0; i < 150; i++) begin
      bit sa;
      case ($urandom_range(0, 3))
        0:       a = (16'($urandom) & ~16'hE100) | 16'h4100;
        1:       a = 16'h8000 | 16'($urandom);
        2:       a = 16'($urandom) & 16'h7FFF;
        default: a = 16'($urandom);
      endcase
      sa = ($urandom_range(0, 7) == 0);
      bus(a, 8'($urandom), 1'($urandom_range(0, 3) == 0), 8'($urandom),
          sa, sa & 1'($urandom), $urandom_range(0, 4), 0, "rand");
    end

    for (int i = 0; i < 300; i++)
      bus(16'h4100, 8'($urandom), 1'b0, 8'($urandom), 0, 0, 0, 0, "sat");
    ss_act = 1'b1;
    ss_addr = SS_WCNT;
    check("sat_final", 1'b0);
    cmp("sat_final", "a_wr_cnt", 32'(a_ss), 32'd255);

    @(posedge clk); #2;
    cpu_addr = 16'h4100; cpu_ce = 1'b0; cpu_dat = 8'hFF; cpu_rw = 1'b0;
    ss_act = 1'b0; ss_we = 1'b0; m2 = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #2 m2 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2 check("rst_mid", 1'b1);
    #2 check("rst_mid2", 1'b1);
    bus(16'h4100, 8'h9B, 1'b0, 8'h00, 0, 0, 0, 1, "post_rst");

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
